scan_controller: RTL and testbench
==================================

// Module: scan_controller
// PURPOSE
//  Parametrised multiplexed-display scan controller for N common-anode 7-segment digits.
//  Has a built-in refresh prescaler, so no external pix_ticker is instantiated.
//  Adds per-digit blanking with skip-scan, PWM brightness control and anti-ghost dead time.
//  Drives active-low anode enables, plus a digit-select index for the upstream segment mux.
// PARAMETERS
//  NUM_DIGITS  8            number of digits scanned (2..16)
//  SEL_W       3            select width; must equal clog2(NUM_DIGITS)
//  CLK_HZ      100_000_000  input clock frequency
//  REFRESH_HZ  480          digit-slot rate; DIV = CLK_HZ/REFRESH_HZ cycles per slot (DIV >= 2^BRIGHT_W)
//  BRIGHT_W    4            brightness code width
//  DEAD_CYC    4            anode-off cycles at the start of each slot (0 = none, < DIV)
// PORTS
//  clk         in   1           system clock
//  reset_n     in   1           asynchronous, active-low reset
//  en          in   1           global enable; 0 freezes scan and blanks all anodes
//  digit_en    in   NUM_DIGITS  per-digit enable; bit i=0 -> digit i skipped/blanked
//  brightness  in   BRIGHT_W    PWM duty code; on-time = (brightness+1)/2^BRIGHT_W
//  anode       out  NUM_DIGITS  active-low anode enables (registered)
//  sel         out  SEL_W       index of current digit for segment mux (registered)
//  digit_tick  out  1           one-cycle pulse on the cycle sel updates
// BEHAVIOUR
//  Reset (reset_n=0, async): anode=all 1s, sel=0, digit_tick=0; prescaler, PWM and dead counters=0.
//  Prescaler: counts 0..DIV-1 while en=1; wrap asserts internal adv for one cycle. Holds when en=0.
//  On adv: sel <= next index after sel, searching upward with wrap, whose digit_en bit is 1.
//    - Wrap from NUM_DIGITS-1 to 0. If only the current digit is enabled, sel holds.
//    - If no bit is set, sel holds and digit_tick is still pulsed.
//  Latency: sel and digit_tick update on the edge following the prescaler wrap.
//    - sel is stable for exactly DIV cycles per slot.
//  Dead time: for DEAD_CYC cycles starting with the cycle sel changes, anode = all 1s.
//  PWM: a free-running BRIGHT_W-bit counter, reset to 0 on every adv.
//    - Digit is lit only while pwm_cnt <= brightness.
//    - brightness = all 1s -> lit for the whole non-dead slot; 0 -> 1/2^BRIGHT_W duty.
//  anode[i] = 0 iff en & digit_en[sel] & (i==sel) & ~dead & pwm_on, registered with one-cycle lag.
//    - All other anode bits are 1; at most one bit is ever 0.
//  Changes to digit_en/brightness mid-slot take effect on the next clock (blank) or next adv (sel).
//  en falling mid-slot: anode -> all 1s next cycle; prescaler and sel frozen.
//    - When en returns, the scan resumes from the frozen count.
//  reset_n asserted mid-slot: outputs go to reset values immediately.
//    - After release, the first adv occurs DIV cycles later, moving sel to the first enabled digit after 0.
//  sel never exceeds NUM_DIGITS-1, including for non-power-of-2 NUM_DIGITS.
// TESTING (sim params: CLK_HZ=3200, REFRESH_HZ=100 -> DIV=32, BRIGHT_W=4, NUM_DIGITS=8)
//  1. DEAD_CYC=0, digit_en=FF, brightness=F, en=1
//     -> sel 0,1..7,0 every 32 cycles; anode FE,FD,..,7F; digit_tick period 32.
//  2. digit_en=8'hA5 -> sel sequence 0,2,5,7,0,...; anode never lights digits 1,3,4,6.
//  3. digit_en=00 -> anode stays FF; sel frozen; digit_tick still every 32 cycles.
//  4. brightness=3, DEAD_CYC=0 -> within each slot, anode low for 4 of every 16 cycles (8 of 32 per slot).
//  5. DEAD_CYC=2 -> for 2 cycles after each sel change anode=FF, then the selected digit goes low.
//  6. reset_n low for 3 cycles at slot cycle 10 of sel=4
//     -> anode=FF, sel=0 asynchronously; first digit_tick 32 cycles after release.
//  7. NUM_DIGITS=6, SEL_W=3 -> sel wraps 5->0, never reaches 6 or 7.

Source files
------------

// File: rtl/scan_controller.sv
// Multiplexed 7-segment scan controller: prescaled digit slots, skip-scan over
// disabled digits, PWM brightness and anti-ghost dead time at each slot start.
// Anode enables are active-low. The select index feeds the upstream segment mux.
module scan_controller #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 480,
    parameter int unsigned BRIGHT_W   = 4,
    parameter int unsigned DEAD_CYC   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [SEL_W-1:0]      sel,
    output logic                  digit_tick
);

    localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d, next_sel;
    logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
    logic                  tick_q;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  adv;
    logic                  dead;
    logic                  pwm_on;
    logic                  lit;

    // Slot prescaler and PWM counter; both freeze while the scan is disabled
    always_comb begin
        adv   = en && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        pwm_d = pwm_q;
        if (en) begin
            cnt_d = adv ? '0 : cnt_q + CNT_W'(1);
            pwm_d = adv ? '0 : pwm_q + BRIGHT_W'(1);
        end
    end

    // Next enabled digit above sel with wrap; the smallest offset wins, and
    // offset NUM_DIGITS lands back on sel itself when it is the only one enabled
    always_comb begin
        int cand;
        cand     = 0;
        next_sel = sel_q;
        for (int k = int'(NUM_DIGITS); k > 0; k--) begin
            cand = int'(sel_q) + k;
            if (cand >= int'(NUM_DIGITS)) begin
                cand = cand - int'(NUM_DIGITS);
            end
            if (digit_en[SEL_W'(cand)]) begin
                next_sel = SEL_W'(cand);
            end
        end
    end

    assign sel_d = adv ? next_sel : sel_q;

    // Dead window is measured on the upcoming slot count so it lines up with sel
    if (DEAD_CYC == 0) begin : g_no_dead
        assign dead = 1'b0;
    end else begin : g_dead
        assign dead = (32'(cnt_d) < DEAD_CYC);
    end

    assign pwm_on = (pwm_d <= brightness);
    assign lit    = en && digit_en[sel_d] && !dead && pwm_on;

    // Anode pattern for the next cycle: at most the selected digit is driven low
    always_comb begin
        anode_d = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            anode_d[i] = !(lit && (sel_d == SEL_W'(i)));
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            anode_q <= '1;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pwm_q   <= pwm_d;
            tick_q  <= adv;
            anode_q <= anode_d;
        end
    end

    assign anode      = anode_q;
    assign sel        = sel_q;
    assign digit_tick = tick_q;

endmodule

// File: tb/tb_scan_controller.sv
// Bench for scan_controller: three instances (8 digits no dead time, 8 digits
// with 2 dead cycles, 6 digits) share clock, reset, enable and brightness.
// Per-slot expectations are queued as stimulus is set and checked per slot.
module tb_scan_controller;

    typedef struct packed {
        logic [2:0] sel;
        logic [5:0] lit;
        logic [5:0] lead;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] de8;
    logic [5:0] de6;
    logic [3:0] brightness;

    logic [7:0] an0, an1;
    logic [5:0] an2;
    logic [2:0] s0, s1, s2;
    logic       t0, t1, t2;

    logic [7:0] an_w [3];
    logic [2:0] sl_w [3];
    logic       tk_w [3];

    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    scan_controller #(.NUM_DIGITS(8), .SEL_W(3), .CLK_HZ(3200), .REFRESH_HZ(100),
                      .BRIGHT_W(4), .DEAD_CYC(0)) u0 (
        .clk(clk), .reset_n(reset_n), .en(en), .digit_en(de8), .brightness(brightness),
        .anode(an0), .sel(s0), .digit_tick(t0));

    scan_controller #(.NUM_DIGITS(8), .SEL_W(3), .CLK_HZ(3200), .REFRESH_HZ(100),
                      .BRIGHT_W(4), .DEAD_CYC(2)) u1 (
        .clk(clk), .reset_n(reset_n), .en(en), .digit_en(de8), .brightness(brightness),
        .anode(an1), .sel(s1), .digit_tick(t1));

    scan_controller #(.NUM_DIGITS(6), .SEL_W(3), .CLK_HZ(3200), .REFRESH_HZ(100),
                      .BRIGHT_W(4), .DEAD_CYC(0)) u2 (
        .clk(clk), .reset_n(reset_n), .en(en), .digit_en(de6), .brightness(brightness),
        .anode(an2), .sel(s2), .digit_tick(t2));

    assign an_w[0] = an0;
    assign an_w[1] = an1;
    assign an_w[2] = {2'b11, an2};
    assign sl_w[0] = s0;
    assign sl_w[1] = s1;
    assign sl_w[2] = s2;
    assign tk_w[0] = t0;
    assign tk_w[1] = t1;
    assign tk_w[2] = t2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // u0 and u2 have no dead time; u1 follows u0's select with 2 dead cycles
    task automatic push_slot(input int s8, input int s6, input int lit_a, input int lead_a,
                             input int lit_b, input int lead_b);
        exp_t e;
        e.sel = 3'(s8); e.lit = 6'(lit_a); e.lead = 6'(lead_a); exp_q.push_back(e);
        e.sel = 3'(s8); e.lit = 6'(lit_b); e.lead = 6'(lead_b); exp_q.push_back(e);
        e.sel = 3'(s6); e.lit = 6'(lit_a); e.lead = 6'(lead_a); exp_q.push_back(e);
    endtask

    // Wait for the next digit_tick, then observe the 32-cycle slot it opens
    task automatic run_slot(input int exp_wait, input string tag);
        exp_t e [3];
        int   n;
        int   lit [3];
        int   lead [3];
        int   bad [3];
        bit   run [3];
        logic seen;
        for (int i = 0; i < 3; i++) begin
            e[i]    = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            lit[i]  = 0;
            lead[i] = 0;
            bad[i]  = 0;
            run[i]  = 1'b1;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = t0;
        end
        chk($sformatf("%s_tick_wait", tag), 32'(n), 32'(exp_wait));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_sel%0d", tag, i), 32'(sl_w[i]), 32'(e[i].sel));
        end
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (an_w[i] == 8'hFF) begin
                    if (run[i]) lead[i]++;
                end else begin
                    run[i] = 1'b0;
                    if (an_w[i] == ~(8'h01 << e[i].sel)) lit[i]++;
                    else bad[i]++;
                end
                if (c > 0 && tk_w[i]) bad[i]++;
                if (c == 0 && !tk_w[i]) bad[i]++;
                if (sl_w[i] != e[i].sel) bad[i]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_lit%0d", tag, i), 32'(lit[i]), 32'(e[i].lit));
            chk($sformatf("%s_lead%0d", tag, i), 32'(lead[i]), 32'(e[i].lead));
            chk($sformatf("%s_bad%0d", tag, i), 32'(bad[i]), 32'(0));
        end
    endtask

    initial begin
        int   b8 [5] = '{2, 5, 7, 0, 2};
        int   b6 [5] = '{5, 0, 2, 5, 0};
        int   n;
        int   bad_cnt;
        logic seen;

        reset_n    = 1'b0;
        en         = 1'b1;
        de8        = 8'hFF;
        de6        = 6'h3F;
        brightness = 4'hF;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_anode%0d", i), 32'(an_w[i]), 32'hFF);
            chk($sformatf("reset_sel%0d", i), 32'(sl_w[i]), 32'(0));
            chk($sformatf("reset_tick%0d", i), 32'(tk_w[i]), 32'(0));
        end
        reset_n = 1'b1;

        // Full scan, every digit enabled, full brightness
        for (int k = 0; k < 9; k++) begin
            push_slot((k + 1) % 8, (k + 1) % 6, 32, 0, 30, 2);
            run_slot((k == 0) ? 32 : 1, "scan_all");
        end

        // Skip-scan over disabled digits
        de8 = 8'hA5;
        de6 = 6'b100101;
        for (int k = 0; k < 5; k++) begin
            push_slot(b8[k], b6[k], 32, 0, 30, 2);
            run_slot(1, "skip");
        end

        // PWM brightness 3: 4 of every 16 cycles lit
        de8        = 8'hFF;
        de6        = 6'h3F;
        brightness = 4'h3;
        for (int k = 0; k < 3; k++) begin
            push_slot(k + 3, k + 1, 8, 0, 6, 2);
            run_slot(1, "pwm3");
        end

        // No digit enabled: sel holds, ticks continue, all blank
        de8        = 8'h00;
        de6        = 6'h00;
        brightness = 4'hF;
        for (int k = 0; k < 3; k++) begin
            push_slot(5, 3, 0, 32, 0, 32);
            run_slot(1, "none_en");
        end

        // Only the current digit enabled: sel holds and stays lit
        de8 = 8'h20;
        de6 = 6'h08;
        for (int k = 0; k < 2; k++) begin
            push_slot(5, 3, 32, 0, 30, 2);
            run_slot(1, "only_cur");
        end

        // Global enable low: blank, frozen, then resume from the frozen count
        en      = 1'b0;
        bad_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (an_w[i] != 8'hFF || tk_w[i]) bad_cnt++;
            end
            if (s0 != 3'd5 || s1 != 3'd5 || s2 != 3'd3) bad_cnt++;
        end
        chk("en_low_frozen", 32'(bad_cnt), 32'(0));
        en  = 1'b1;
        de8 = 8'hFF;
        de6 = 6'h3F;
        for (int k = 0; k < 6; k++) begin
            push_slot((6 + k) % 8, (4 + k) % 6, 32, 0, 30, 2);
            run_slot(1, "resume");
        end

        // Asynchronous reset at slot cycle 10 of sel=4
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = t0;
        end
        chk("rst_pre_wait", 32'(n), 32'(1));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_pre_sel%0d", i), 32'(sl_w[i]), 32'(4));
        end
        repeat (10) @(negedge clk);
        chk("rst_pre_anode", 32'(an0), 32'hEF);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_async_anode%0d", i), 32'(an_w[i]), 32'hFF);
            chk($sformatf("rst_async_sel%0d", i), 32'(sl_w[i]), 32'(0));
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        push_slot(1, 1, 32, 0, 30, 2);
        run_slot(32, "post_rst");
        push_slot(2, 2, 32, 0, 30, 2);
        run_slot(1, "post_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
